mnist_score_accum: RTL

MNIST_SCORE_ACCUM -- requirements
Module: mnist_score_accum

---
 rtl/mnist_score_accum.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mnist_score_accum.sv
// mnist_score_accum: scores a run of N_SAMPLES classifier results against
// their true labels and reports the running correct/total counts.
//
// Optional feature macro: MNIST_SCORE_AMBIG_EN
//   defined   : multi-hot in_result is ambiguous (pred_class=4'hF, never
//               correct) and is counted on the extra ambig_cnt port.
//   undefined : multi-hot in_result resolves to its lowest set index.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        one-cycle request to begin a run (ignored while busy)
//   in_valid     in_result / in_label valid this cycle
//   in_result    [9:0] per-class match bits, bit k = class k
//   in_label     [3:0] true class of the sample
//   busy         high while a run is accumulating
//   done         one-cycle pulse with the final counter update
//   pred_valid   one-cycle strobe per scored sample
//   pred_class   [3:0] predicted class, 4'hF = no prediction
//   correct_cnt  [CNT_W-1:0] correctly predicted samples this run
//   total_cnt    [CNT_W-1:0] samples scored this run
//   ambig_cnt    [CNT_W-1:0] multi-hot samples (MNIST_SCORE_AMBIG_EN only)
module mnist_score_accum #(
  parameter int unsigned N_SAMPLES = 2048,
  parameter int unsigned CNT_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [9:0]       in_result,
  input  logic [3:0]       in_label,
  output logic             busy,
  output logic             done,
  output logic             pred_valid,
  output logic [3:0]       pred_class,
  output logic [CNT_W-1:0] correct_cnt,
  output logic [CNT_W-1:0] total_cnt
`ifdef MNIST_SCORE_AMBIG_EN
  ,
  output logic [CNT_W-1:0] ambig_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0]       NO_PRED  = 4'hF;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             r_busy;
  logic             r_done;
  logic             r_pred_valid;
  logic [3:0]       r_pred_class;
  logic [CNT_W-1:0] r_correct;
  logic [CNT_W-1:0] r_total;

  logic             w_accept;
  logic             w_start;
  logic             w_last;
  logic [3:0]       w_low;
  logic [3:0]       w_pred;
  logic             w_correct;

`ifdef MNIST_SCORE_AMBIG_EN
  logic [CNT_W-1:0] r_ambig;
  logic [3:0]       w_hot;
  logic             w_multi;
`endif

  // Qualified events: start only counts outside ACC, samples only inside ACC.
  assign w_accept = (r_state == ACC) && in_valid;
  assign w_start  = start && (r_state != ACC);
  assign w_last   = w_accept && (r_total == LAST_IDX);

  // Class decode: lowest set index, or NO_PRED for an all-zero vector.
  always_comb begin
    w_low = NO_PRED;
    for (int k = 9; k >= 0; k--) begin
      if (in_result[k]) w_low = 4'(k);
    end
  end

`ifdef MNIST_SCORE_AMBIG_EN
  // Multi-hot detection overrides the decoded class.
  always_comb begin
    w_hot = 4'd0;
    for (int k = 0; k < 10; k++) begin
      w_hot = w_hot + 4'(in_result[k]);
    end
  end
  assign w_multi = (w_hot > 4'd1);
  assign w_pred  = w_multi ? NO_PRED : w_low;
`else
  assign w_pred = w_low;
`endif

  // A label above 9 can never equal a decoded class, so no extra range check.
  assign w_correct = (w_pred != NO_PRED) && (w_pred == in_label);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = ACC;
      ACC:     if (w_last) w_next = DONE;
      DONE:    if (start)  w_next = ACC;
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs and run counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_class <= NO_PRED;
      r_correct    <= '0;
      r_total      <= '0;
    end else begin
      r_busy       <= (w_next == ACC);
      r_done       <= w_last;
      r_pred_valid <= w_accept;
      if (w_start) begin
        r_correct <= '0;
        r_total   <= '0;
      end else if (w_accept) begin
        r_pred_class <= w_pred;
        r_total      <= r_total + CNT_W'(1);
        if (w_correct) r_correct <= r_correct + CNT_W'(1);
      end
    end
  end

`ifdef MNIST_SCORE_AMBIG_EN
  // Ambiguous-sample counter, cleared with the other run counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ambig <= '0;
    end else if (w_start) begin
      r_ambig <= '0;
    end else if (w_accept && w_multi) begin
      r_ambig <= r_ambig + CNT_W'(1);
    end
  end
  assign ambig_cnt = r_ambig;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign pred_valid  = r_pred_valid;
  assign pred_class  = r_pred_class;
  assign correct_cnt = r_correct;
  assign total_cnt   = r_total;

endmodule
